// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core_ctrl instruction sequencer: FSM states,
// inst word bit positions, the idle word and small inst-building helpers.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_L0,
        ST_W_LOAD,
        ST_W_FLUSH,
        ST_X_L0,
        ST_X_EXEC,
        ST_X_FLUSH,
        ST_WB,
        ST_ACC,
        ST_DONE
    } state_t;

    localparam int unsigned INST_W = 34;
    localparam int unsigned ADDR_W = 11;

    localparam int unsigned INST_ACC        = 33;
    localparam int unsigned INST_CEN_PMEM   = 32;
    localparam int unsigned INST_WEN_PMEM   = 31;
    localparam int unsigned INST_A_PMEM_LSB = 20;
    localparam int unsigned INST_CEN_XMEM   = 19;
    localparam int unsigned INST_WEN_XMEM   = 18;
    localparam int unsigned INST_A_XMEM_LSB = 7;
    localparam int unsigned INST_OFIFO_RD   = 6;
    localparam int unsigned INST_IFIFO_WR   = 5;
    localparam int unsigned INST_IFIFO_RD   = 4;
    localparam int unsigned INST_L0_RD      = 3;
    localparam int unsigned INST_L0_WR      = 2;
    localparam int unsigned INST_EXECUTE    = 1;
    localparam int unsigned INST_LOAD       = 0;

    // Both SRAMs deselected with write disabled; every other strobe low.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    function automatic logic [INST_W-1:0] inst_xmem_rd(input logic [ADDR_W-1:0] addr);
        logic [INST_W-1:0] w;
        w = INST_IDLE;
        w[INST_CEN_XMEM] = 1'b0;
        w[INST_A_XMEM_LSB +: ADDR_W] = addr;
        return w;
    endfunction

    function automatic logic [INST_W-1:0] inst_pmem(input logic wen, input logic [ADDR_W-1:0] addr);
        logic [INST_W-1:0] w;
        w = INST_IDLE;
        w[INST_CEN_PMEM] = 1'b0;
        w[INST_WEN_PMEM] = wen;
        w[INST_A_PMEM_LSB +: ADDR_W] = addr;
        return w;
    endfunction

endpackage

// File: rtl/core_ctrl_acc_addr.sv
// ACC-phase pmem address: partial sum of kernel position k that
// contributes to output pixel o.
module core_ctrl_acc_addr
    import core_ctrl_pkg::*;
#(
    parameter int unsigned len_nij = 36,
    parameter int unsigned in_w    = 6,
    parameter int unsigned k_w     = 3,
    parameter int unsigned out_w   = 4
) (
    input  logic [7:0]        i_o,
    input  logic [3:0]        i_k,
    output logic [ADDR_W-1:0] o_addr
);

    logic [31:0] w_o;
    logic [31:0] w_k;

    assign w_o = 32'(i_o);
    assign w_k = 32'(i_k);

    assign o_addr = ADDR_W'(w_k * len_nij
                            + (w_o / out_w + w_k / k_w) * in_w
                            + w_o % out_w
                            + w_k % k_w);

endmodule

// File: rtl/core_ctrl.sv
// Layer sequencer for core: emits one registered 34-bit inst word per cycle.
// Optional CORE_CTRL_PERF_CNT_EN adds the stall_cnt WB-stall counter output.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned row      = 8,
    parameter int unsigned col      = 8,
    parameter int unsigned len_kij  = 9,
    parameter int unsigned len_nij  = 36,
    parameter int unsigned len_onij = 16,
    parameter int unsigned in_w     = 6,
    parameter int unsigned k_w      = 3,
    parameter int unsigned out_w    = 4,
    parameter int unsigned W_BASE   = 1024,
    parameter int unsigned FLUSH    = row + col
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        kij_idx
`ifdef CORE_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [3:0]          r_kij;
    logic [7:0]          r_o;
    logic [3:0]          r_k;
    logic [INST_W-1:0]   r_inst;
    logic                r_busy;
    logic                r_done;
`ifdef CORE_CTRL_PERF_CNT_EN
    logic [15:0]         r_stall;
`endif

    logic [ADDR_W-1:0]   w_waddr;
    logic [ADDR_W-1:0]   w_wbaddr;
    logic [ADDR_W-1:0]   w_accaddr;

    assign w_waddr  = ADDR_W'(W_BASE + 32'(r_kij) * col + 32'(r_cnt));
    assign w_wbaddr = ADDR_W'(32'(r_kij) * len_nij + 32'(r_cnt));

    core_ctrl_acc_addr #(
        .len_nij (len_nij),
        .in_w    (in_w),
        .k_w     (k_w),
        .out_w   (out_w)
    ) u_acc_addr (
        .i_o    (r_o),
        .i_k    (r_k),
        .o_addr (w_accaddr)
    );

    // Each edge registers the word for the step the counters point at, then
    // advances; r_inst therefore trails r_state by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_kij   <= '0;
            r_o     <= '0;
            r_k     <= '0;
            r_inst  <= INST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef CORE_CTRL_PERF_CNT_EN
            r_stall <= '0;
`endif
        end else begin
            r_inst <= INST_IDLE;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_W_L0;
                        r_cnt   <= '0;
                        r_kij   <= '0;
                        r_busy  <= 1'b1;
`ifdef CORE_CTRL_PERF_CNT_EN
                        r_stall <= '0;
`endif
                    end
                end
                ST_W_L0: begin
                    if (r_cnt != ADDR_W'(col))
                        r_inst <= inst_xmem_rd(w_waddr);
                    r_inst[INST_L0_WR] <= (r_cnt != '0);
                    if (r_cnt == ADDR_W'(col)) begin
                        r_state <= ST_W_LOAD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_W_LOAD: begin
                    r_inst[INST_L0_RD] <= 1'b1;
                    r_inst[INST_LOAD]  <= 1'b1;
                    if (r_cnt == ADDR_W'(col - 1)) begin
                        r_state <= ST_W_FLUSH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_W_FLUSH: begin
                    if (r_cnt == ADDR_W'(FLUSH - 1)) begin
                        r_state <= ST_X_L0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_X_L0: begin
                    if (r_cnt != ADDR_W'(len_nij))
                        r_inst <= inst_xmem_rd(r_cnt);
                    r_inst[INST_L0_WR] <= (r_cnt != '0);
                    if (r_cnt == ADDR_W'(len_nij)) begin
                        r_state <= ST_X_EXEC;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_X_EXEC: begin
                    r_inst[INST_L0_RD]   <= 1'b1;
                    r_inst[INST_EXECUTE] <= 1'b1;
                    if (r_cnt == ADDR_W'(len_nij - 1)) begin
                        r_state <= ST_X_FLUSH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_X_FLUSH: begin
                    if (r_cnt == ADDR_W'(FLUSH - 1)) begin
                        r_state <= ST_WB;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    if (ofifo_valid) begin
                        r_inst <= inst_pmem(1'b0, w_wbaddr);
                        r_inst[INST_OFIFO_RD] <= 1'b1;
                        if (r_cnt == ADDR_W'(len_nij - 1)) begin
                            r_cnt <= '0;
                            if (r_kij == 4'(len_kij - 1)) begin
                                r_state <= ST_ACC;
                                r_o     <= '0;
                                r_k     <= '0;
                            end else begin
                                r_state <= ST_W_L0;
                                r_kij   <= r_kij + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`ifdef CORE_CTRL_PERF_CNT_EN
                    else if (r_stall != 16'hFFFF) begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                ST_ACC: begin
                    // r_k == len_kij is the acc=0 separator after each output pixel.
                    if (r_k == 4'(len_kij)) begin
                        r_k <= '0;
                        if (r_o == 8'(len_onij - 1))
                            r_state <= ST_DONE;
                        else
                            r_o <= r_o + 1'b1;
                    end else begin
                        r_inst <= inst_pmem(1'b1, w_accaddr);
                        r_inst[INST_ACC] <= 1'b1;
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign inst    = r_inst;
    assign busy    = r_busy;
    assign done    = r_done;
    assign kij_idx = r_kij;
`ifdef CORE_CTRL_PERF_CNT_EN
    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Directed testbench for core_ctrl: reset values, full layers, WB stalls,
// mid-layer reset and start handling around WB and DONE.
module tb_core_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij_idx;
`ifdef CORE_CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    core_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .kij_idx     (kij_idx)
`ifdef CORE_CTRL_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc, n_load, n_wphase, n_wr, n_wr_bad, n_k2, k2_l0wr_cyc;
    int n_acc, n_acc_bad, acc49, n_gap, n_done;
    int k2_addr [8];
    int k2_cyc  [8];
    logic prev_load, prev_acc;
    logic [3:0] rd_pat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_tallies();
        cyc = 0; n_load = 0; n_wphase = 0; n_wr = 0; n_wr_bad = 0; n_k2 = 0;
        k2_l0wr_cyc = -1; n_acc = 0; n_acc_bad = 0; acc49 = -1; n_gap = 0; n_done = 0;
        prev_load = 1'b0; prev_acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k2_addr[i] = -1;
            k2_cyc[i]  = -1;
        end
    endtask

    task automatic observe();
        cyc++;
        if (inst[0]) begin
            n_load++;
            if (!prev_load) n_wphase++;
        end
        if (!inst[32] && !inst[31]) begin
            if (int'(inst[30:20]) != n_wr || !inst[6]) n_wr_bad++;
            n_wr++;
        end else if (inst[6]) begin
            n_wr_bad++;
        end
        if (!inst[19] && kij_idx == 4'd2 && n_k2 < 8) begin
            k2_addr[n_k2] = int'(inst[17:7]);
            k2_cyc[n_k2]  = cyc;
            n_k2++;
        end
        if (inst[2] && kij_idx == 4'd2 && k2_l0wr_cyc < 0) k2_l0wr_cyc = cyc;
        if (inst[33]) begin
            if (inst[32] || !inst[31]) n_acc_bad++;
            if (n_acc == 49) acc49 = int'(inst[30:20]);
            n_acc++;
        end
        if (prev_acc && !inst[33]) n_gap++;
        if (done) n_done++;
        prev_load = inst[0];
        prev_acc  = inst[33];
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        observe();
    endtask

    task automatic check_full_layer(input string pfx);
        check({pfx, "_done_once"}, 64'(n_done), 64'd1);
        check({pfx, "_pmem_writes"}, 64'(n_wr), 64'd324);
        check({pfx, "_pmem_order"}, 64'(n_wr_bad), 64'd0);
        check({pfx, "_weight_phases"}, 64'(n_wphase), 64'd9);
        check({pfx, "_acc_gaps"}, 64'(n_gap), 64'd16);
        check({pfx, "_acc_o5_k4_addr"}, 64'(acc49), 64'd158);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b1;
        clear_tallies();

        repeat (2) @(negedge clk);
        check("rst_inst", 64'(inst), 64'h1_800C_0000);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_kij", 64'(kij_idx), 64'd0);
`ifdef CORE_CTRL_PERF_CNT_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        reset = 1'b1;
        tick();

        // Layer 1: start pulse, stall pattern in the first WB, start during WB.
        clear_tallies();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < 500 && n_wr == 0; i++) tick();
        check("wb_reached", 64'(n_wr), 64'd1);

        ofifo_valid = 1'b1; start = 1'b1;
        tick(); rd_pat[3] = inst[6];
        start = 1'b0; ofifo_valid = 1'b0;
        tick(); rd_pat[2] = inst[6];
        tick(); rd_pat[1] = inst[6];
        ofifo_valid = 1'b1;
        tick(); rd_pat[0] = inst[6];
        check("wb_rd_pattern", 64'(rd_pat), 64'b1001);
        check("wb_writes_after_stall", 64'(n_wr), 64'd3);
        check("wb_start_ignored_busy", 64'(busy), 64'd1);
        check("wb_start_ignored_kij", 64'(kij_idx), 64'd0);
`ifdef CORE_CTRL_PERF_CNT_EN
        check("stall_cnt_after_pattern", 64'(stall_cnt), 64'd2);
`endif

        for (int i = 0; i < 3000 && n_done == 0; i++) tick();
        repeat (3) tick();
        check_full_layer("l1");
        check("l1_load_cycles", 64'(n_load), 64'd72);
        check("l1_acc_reads", 64'(n_acc), 64'd144);
        check("l1_acc_strobes", 64'(n_acc_bad), 64'd0);
        for (int i = 0; i < 8; i++)
            check($sformatf("k2_xmem_addr%0d", i), 64'(k2_addr[i]), 64'(1040 + i));
        check("k2_l0wr_lag", 64'(k2_l0wr_cyc - k2_cyc[0]), 64'd1);
        check("l1_busy_after_done", 64'(busy), 64'd0);
`ifdef CORE_CTRL_PERF_CNT_EN
        check("stall_cnt_end_layer", 64'(stall_cnt), 64'd2);
`endif

        // Layer 2: asynchronous reset during execute.
        clear_tallies();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && !inst[1]; i++) tick();
        check("exec_reached", 64'(inst[1]), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_inst", 64'(inst), 64'h1_800C_0000);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_kij", 64'(kij_idx), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("postrst_inst", 64'(inst), 64'h1_800C_0000);
        check("postrst_busy", 64'(busy), 64'd0);

        // Layer 3: start held high through DONE.
        clear_tallies();
        start = 1'b1;
        for (int i = 0; i < 3000 && n_done == 0; i++) tick();
        check("held_done_busy", 64'(busy), 64'd0);
        check_full_layer("l3");
        tick();
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_done_low", 64'(done), 64'd0);
        check("restart_kij", 64'(kij_idx), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
